theta_slice_loader: RTL and testbench
=====================================

Name: theta_slice_loader

Overview:
- Sits directly downstream of the 25-bit slice file reader and also controls it.
- Sequences line requests 1..64 to the reader and captures each returned 25-bit slice into a 64-entry state buffer, computing column parities on the fly.
- Streams out the theta-transformed slices (Keccak theta on a 5x5x64 state) over a valid/ready interface.
- Feeds the encoder round datapath.

Parameters:
- N, 25, slice width; fixed at 25 (5x5). Other values are unsupported.
- DEPTH, 64, number of slices (lanes of 64 bits); must be 64.
- LINE_W, 7, width of the reader line-number port.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  input  1  one-cycle request to load and process one full state.
- busy  output  1  high from the cycle after an accepted start until the done cycle inclusive.
- done  output  1  one-cycle pulse after the last output slice handshake.
- rd_ld  output  1  load strobe to the reader.
- rd_line  output  LINE_W  requested line number; 1-based, 1..64.
- rd_data  input  N  reader output (pout).
- out_valid  output  1  out_slice/out_index valid.
- out_ready  input  1  downstream accepts when high together with out_valid.
- out_slice  output  N  theta-applied slice.
- out_index  output  6  slice index z, 0..63.

Behaviour:
- Bit mapping: slice bit i = 5*y + x, with x,y in 0..4. Reader line L holds slice z = L-1.
- Reset (rst low at a clock edge): FSM to IDLE; busy, done, rd_ld, out_valid = 0; rd_line = 0; out_slice = 0; out_index = 0; load and output counters = 0. The buffer and parity array are not cleared; they are fully overwritten before any use.
- Reader timing: the reader registers rd_data on the edge that samples rd_ld=1. The data for the request issued in cycle k is therefore captured at the edge ending cycle k+1.
- IDLE:
  - start=1 -> LOAD.
  - start while in any other state is ignored.
- LOAD (65 cycles, one request per cycle, pipelined):
  - Cycles 0..63: rd_ld=1, rd_line = cycle+1.
  - Cycles 1..64: capture rd_data into buf[cycle-1].
  - On each capture, compute par[z][x] = XOR over y of bit(5y+x) and store it.
  - After capture of z=63 -> STREAM; rd_ld=0 from then on.
- STREAM:
  - out_valid=1, out_index = z. Starts at z=0; the first slice is presented in the first STREAM cycle.
  - out_slice bit(x,y) = buf[z] bit(x,y) ^ par[z][(x+4)%5] ^ par[(z+63)%64][(x+1)%5].
  - The z-1 term wraps: z=0 uses par[63].
  - On out_valid & out_ready: z increments. After the z=63 handshake -> DONE.
  - While out_ready=0, out_slice and out_index hold stable.
- DONE: done=1 for one cycle; busy=1 in this cycle; then -> IDLE.
- Registering and latency:
  - out_slice/out_index are registered: the next slice appears the cycle after a handshake.
  - Full throughput is 1 slice/cycle with out_ready held high.
  - Start-to-done latency with no backpressure = 1 + 65 + 64 + 1 cycles.
- rst low mid-LOAD or mid-STREAM: immediate return to the reset values. A subsequent start re-reads all 64 lines. No partial output resumes.
- Parity arithmetic is pure XOR; there are no carries or width growth.

Decomposition:
- Shared package:
  - Constants SLICE_W=25, NUM_SLICES=64, NUM_COLS=5.
  - FSM state enum {IDLE, LOAD, STREAM, DONE}.
  - Function bit_idx(x,y) = 5*y+x.
  - Function col_parity(slice) returning 5 bits.
- One sub-module: theta_slice_comb. It is purely combinational: inputs are the slice, its 5-bit parity and the previous slice's 5-bit parity; output is the theta slice. It is reusable by later round stages.

Test Plan:
1. All-zero input file; start, out_ready=1 -> 64 outputs all 0x0000000, out_index 0..63 in order, done pulses once. Count the cycles from start to done and check them against the latency formula.
2. File with only line 1 = bit 0 set -> out slice 0 = 0x0210843, out slice 1 = 0x1084210, all other slices 0.
3. Wrap-around: only line 64 = bit 0 set -> out slice 63 = 0x0210843, out slice 0 = 0x1084210, others 0.
4. Backpressure: scenario 2 with out_ready=0 for 3 cycles while out_index=1 -> out_slice stays 0x1084210 and out_index stays 1 for all 3 cycles. No slice is duplicated or dropped. Total handshakes = 64.
5. Reset mid-LOAD (rst low at load cycle 30) -> next cycle busy=0, rd_ld=0, out_valid=0. A new start yields output identical to scenario 2. Then start pulsed during STREAM -> ignored; exactly one done occurs.
6. Reader interface check -> rd_line sequence is 1..64 on 64 consecutive rd_ld cycles, and rd_ld is never high outside LOAD.

Source files
------------

// File: rtl/theta_slice_loader_pkg.sv
// theta_slice_loader_pkg: shared constants, FSM states and slice helpers
package theta_slice_loader_pkg;
  localparam int SLICE_W    = 25;
  localparam int NUM_SLICES = 64;
  localparam int NUM_COLS   = 5;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_e;

  function automatic int bit_idx(input int x, input int y);
    return 5 * y + x;
  endfunction

  // Row y occupies bits [5y+4:5y], so column parity is the XOR of the five rows.
  function automatic logic [NUM_COLS-1:0] col_parity(input logic [SLICE_W-1:0] s);
    return s[4:0] ^ s[9:5] ^ s[14:10] ^ s[19:15] ^ s[24:20];
  endfunction
endpackage

// File: rtl/theta_slice_comb.sv
// theta_slice_comb: theta step for one slice given its own and the previous slice's column parity
module theta_slice_comb
  import theta_slice_loader_pkg::*;
(
  input  logic [SLICE_W-1:0]  slice_i,
  input  logic [NUM_COLS-1:0] par_i,
  input  logic [NUM_COLS-1:0] prev_par_i,
  output logic [SLICE_W-1:0]  theta_o
);
  logic [NUM_COLS-1:0] d;
  assign d = {par_i[3:0], par_i[4]} ^ {prev_par_i[0], prev_par_i[4:1]};
  assign theta_o = slice_i ^ {5{d}};
endmodule

// File: rtl/theta_slice_loader.sv
// theta_slice_loader: loads 64 slices from the reader, then streams theta-applied slices
module theta_slice_loader
  import theta_slice_loader_pkg::*;
#(
  parameter int N      = SLICE_W,
  parameter int DEPTH  = NUM_SLICES,
  parameter int LINE_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_ld,
  output logic [LINE_W-1:0] rd_line,
  input  logic [N-1:0]      rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_slice,
  output logic [5:0]        out_index
);
  state_e              state_q, state_d;
  logic [6:0]          lcnt_q, lcnt_d;
  logic [5:0]          z_q, z_d, nz, widx;
  logic [N-1:0]        slice_q, slice_d, th_slice, th_out;
  logic [N-1:0]        buf_q [DEPTH];
  logic [NUM_COLS-1:0] par_q [DEPTH];
  logic [NUM_COLS-1:0] cap_par, th_par, th_prev;
  logic                ld_sel, cap;

  assign ld_sel  = state_q == LOAD;
  assign cap     = ld_sel && lcnt_q != 7'd0;
  assign widx    = lcnt_q[5:0] - 6'd1;
  assign nz      = z_q + 6'd1;
  assign cap_par = col_parity(rd_data);
  // The first output slice needs slice 63's parity, which is being captured in that same cycle.
  assign th_slice = ld_sel ? buf_q[0] : buf_q[nz];
  assign th_par   = ld_sel ? par_q[0] : par_q[nz];
  assign th_prev  = ld_sel ? cap_par  : par_q[z_q];

  theta_slice_comb u_theta (
    .slice_i    (th_slice),
    .par_i      (th_par),
    .prev_par_i (th_prev),
    .theta_o    (th_out)
  );

  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign out_valid = state_q == STREAM;
  assign rd_ld     = ld_sel && !lcnt_q[6];
  assign rd_line   = rd_ld ? LINE_W'(lcnt_q + 7'd1) : '0;
  assign out_slice = slice_q;
  assign out_index = z_q;

  // Slice buffer and parity array capture the reader data one cycle behind each request.
  always_ff @(posedge clk) begin
    if (cap) begin
      buf_q[widx] <= rd_data;
      par_q[widx] <= cap_par;
    end
  end

  // Control state, counters and the registered output slice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      lcnt_q  <= '0;
      z_q     <= '0;
      slice_q <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      z_q     <= z_d;
      slice_q <= slice_d;
    end
  end

  // Next-state: 65 load cycles, one slice per handshake, then a single done cycle.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    z_d     = z_q;
    slice_d = slice_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOAD;
        lcnt_d  = '0;
      end
      LOAD: begin
        lcnt_d = lcnt_q + 7'd1;
        if (lcnt_q == 7'd64) begin
          state_d = STREAM;
          z_d     = '0;
          slice_d = th_out;
        end
      end
      STREAM: if (out_ready) begin
        if (z_q == 6'd63) state_d = DONE;
        else begin
          z_d     = nz;
          slice_d = th_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_theta_slice_loader.sv
// tb_theta_slice_loader: table, directed and randomized checks against a Keccak theta model
module tb_theta_slice_loader;
  logic        clk = 1'b0;
  logic        rst, start, busy, done, rd_ld, out_valid, out_ready;
  logic [6:0]  rd_line;
  logic [24:0] rd_data, out_slice;
  logic [5:0]  out_index;
  logic [24:0] mem [1:64];
  logic        rand_rdy;
  int          cyc = 0;
  int          checks = 0, errors = 0;
  int          exp_line, rd_cnt, line_err, done_cnt, rd_first, rd_last;
  logic [24:0] got_q[$];
  logic [5:0]  idx_q[$];

  theta_slice_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_ld     (rd_ld),
    .rd_line   (rd_line),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_slice (out_slice),
    .out_index (out_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slice file reader: registers the addressed line on a load strobe.
  always @(posedge clk) if (rd_ld) rd_data <= mem[rd_line];

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Passive monitor: collects handshakes, done pulses and reader requests.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        got_q.push_back(out_slice);
        idx_q.push_back(out_index);
      end
      if (done) done_cnt++;
      if (rd_ld) begin
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        if (int'(rd_line) != exp_line) line_err++;
        if (out_valid || done || !busy) line_err++;
        exp_line++;
        rd_cnt++;
      end
    end
  end

  // Keccak theta on the whole state: C[x][z] = XOR_y A, D = C[x-1][z] ^ C[x+1][z-1].
  function automatic logic [24:0] ref_slice(input int z);
    logic [4:0]  c0, c1;
    logic [24:0] r;
    int zp;
    zp = (z + 63) % 64;
    c0 = '0;
    c1 = '0;
    r  = '0;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++) begin
        c0[x] = c0[x] ^ mem[z + 1][5 * y + x];
        c1[x] = c1[x] ^ mem[zp + 1][5 * y + x];
      end
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[5 * y + x] = mem[z + 1][5 * y + x] ^ c0[(x + 4) % 5] ^ c1[(x + 1) % 5];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 1; i <= 64; i++) mem[i] = '0;
  endtask

  task automatic run(output int lat);
    int s;
    got_q.delete();
    idx_q.delete();
    exp_line = 1;
    rd_cnt   = 0;
    line_err = 0;
    done_cnt = 0;
    rd_first = 0;
    rd_last  = 0;
    lat      = -1;
    @(posedge clk); #1 start = 1'b1;
    s = cyc;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc - s + 1;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: no done within 2000 cycles");
    end
  endtask

  task automatic verify_all(input string nm);
    int n;
    repeat (2) @(negedge clk);
    n = got_q.size();
    chk({nm, "_count"}, 64'(n), 64'd64);
    for (int i = 0; i < n && i < 64; i++)
      chk({nm, "_slice"}, {33'd0, idx_q[i], got_q[i]}, {33'd0, 6'(i), ref_slice(i)});
    chk({nm, "_rd_cnt"}, 64'(rd_cnt), 64'd64);
    chk({nm, "_rd_seq"}, 64'(line_err), 64'd0);
    chk({nm, "_rd_span"}, 64'(rd_last - rd_first), 64'd63);
    chk({nm, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  typedef struct {
    int          line;
    logic [24:0] val;
    int          z;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int  lat;
    bit  found;
    vecs[0] = '{0,  25'd0, 5,  25'h0000000};
    vecs[1] = '{1,  25'd1, 0,  25'h0210843};
    vecs[2] = '{1,  25'd1, 1,  25'h1084210};
    vecs[3] = '{1,  25'd1, 2,  25'h0000000};
    vecs[4] = '{64, 25'd1, 63, 25'h0210843};
    vecs[5] = '{64, 25'd1, 0,  25'h1084210};
    vecs[6] = '{64, 25'd1, 62, 25'h0000000};
    rst = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    rand_rdy = 1'b0;
    exp_line = 1; rd_cnt = 0; line_err = 0; done_cnt = 0; rd_first = 0; rd_last = 0;
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {60'd0, busy, done, rd_ld, out_valid}, 64'd0);
    chk("reset_line", 64'(rd_line), 64'd0);
    chk("reset_out", {33'd0, out_index, out_slice}, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    for (int v = 0; v < 7; v++) begin
      clear_mem();
      if (vecs[v].line != 0) mem[vecs[v].line] = vecs[v].val;
      run(lat);
      chk("latency", 64'(lat), 64'd131);
      verify_all("vec");
      chk("vec_exp", {39'd0, got_q.size() > vecs[v].z ? got_q[vecs[v].z] : 25'bx}, {39'd0, vecs[v].exp});
    end
    clear_mem();
    mem[1] = 25'd1;
    fork
      run(lat);
      begin
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (out_valid && out_index == 6'd0) begin
            found = 1'b1;
            break;
          end
        end
        chk("bp_reach", 64'(found), 64'd1);
        if (found) begin
          @(posedge clk); #1 out_ready = 1'b0;
          repeat (3) begin
            @(negedge clk);
            chk("bp_hold", {32'd0, out_valid, out_index, out_slice}, {32'd0, 1'b1, 6'd1, 25'h1084210});
          end
          @(posedge clk); #1 out_ready = 1'b1;
        end
      end
    join
    verify_all("bp");
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_ctl", {61'd0, busy, rd_ld, out_valid}, 64'd0);
    chk("midrst_out", {26'd0, rd_line, out_index, out_slice}, 64'd0);
    run(lat);
    verify_all("rerun");
    fork
      run(lat);
      begin
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (out_valid && out_index == 6'd10) begin
            found = 1'b1;
            break;
          end
        end
        chk("stream_reach", 64'(found), 64'd1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    repeat (150) @(negedge clk);
    chk("ignore_start_busy", 64'(busy), 64'd0);
    verify_all("ignore_start");
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 64; i++) mem[i] = 25'($urandom);
      rand_rdy = 1'b1;
      run(lat);
      rand_rdy = 1'b0;
      out_ready = 1'b1;
      verify_all("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
